// File: rtl/digitron_pkg.sv
// digitron_pkg: shared constants, conversion states and segment lookup for the digitron display
package digitron_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [19:0] MAX_VALUE = 20'd999999;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  localparam logic [9:0][7:0] SEG_CODES = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [23:0] dabble_adj(input logic [23:0] b);
    for (int i = 0; i < NUM_DIGITS; i++)
      dabble_adj[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 20-bit binary to six BCD digits in 22 clocks
module bin2bcd_seq
  import digitron_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd
);
  conv_state_t state;
  logic [43:0] sr;
  logic [4:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sr <= {24'd0, bin > MAX_VALUE ? MAX_VALUE : bin};
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sr <= {dabble_adj(sr[43:20]), sr[19:0]} << 1;
          cnt <= cnt + 5'd1;
          state <= cnt == 5'd19 ? DONE : SHIFT;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bcd = sr[43:20];
endmodule

// File: rtl/digitron_display.sv
// digitron_display: BCD conversion and six-digit multiplexed seven-segment drive with blinking
// Optional DIGITRON_LZB_EN enables leading-zero blanking.
module digitron_display
  import digitron_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] number_to_show,
  input  logic [5:0]  point_position,
  input  logic [5:0]  shank_position,
  output logic [7:0]  seg,
  output logic [5:0]  dig_sel
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0] idx;
  logic blink_phase, conv_busy, conv_done, scan_tc, blink_tc;
  logic [23:0] disp, conv_bcd;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0] lz;
  logic [7:0] seg_next;
`ifdef DIGITRON_LZB_EN
  logic lead;
`endif
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst(rst),
    .start(!conv_busy),
    .bin(number_to_show),
    .busy(conv_busy),
    .done(conv_done),
    .bcd(conv_bcd)
  );
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      digits[i] = disp[4*(NUM_DIGITS-1-i) +: 4];
    lz = '0;
`ifdef DIGITRON_LZB_EN
    lead = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      lead = lead & (digits[i] == 4'd0) & ~point_position[i];
      lz[i] = lead;
    end
`endif
  end
  assign scan_tc = scan_cnt == SW'(SCAN_DIV - 1);
  assign blink_tc = blink_cnt == BW'(BLINK_DIV - 1);
  // Blink blanking and leading-zero blanking both override the decimal point.
  assign seg_next = ((shank_position[idx] && blink_phase) || lz[idx]) ? 8'hFF :
                    {~point_position[idx], SEG_CODES[digits[idx]][6:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      blink_cnt <= '0;
      idx <= '0;
      blink_phase <= 1'b0;
      disp <= '0;
      seg <= 8'hFF;
      dig_sel <= 6'h3F;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
      idx <= scan_tc ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
      blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_tc ? ~blink_phase : blink_phase;
      disp <= conv_done ? conv_bcd : disp;
      seg <= seg_next;
      dig_sel <= ~(6'b1 << idx);
    end
  end
endmodule

// File: tb/tb_digitron_display.sv
// tb_digitron_display: scoreboard bench; expected digit codes queued at stimulus, popped per scanned digit
module tb_digitron_display;
  typedef struct {
    int d;
    logic [7:0] code;
    logic sh;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [19:0] number_to_show = '0;
  logic [5:0] point_position = '0;
  logic [5:0] shank_position = '0;
  logic [7:0] seg;
  logic [5:0] dig_sel;
  int k;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  always #5 clk = ~clk;
  // Edge count since reset release: the edge-k output reflects scan slot (k-1)/4 and blink phase (k-1)/16.
  always @(posedge clk or posedge rst)
    if (rst) k <= 0;
    else k <= k + 1;
  digitron_display #(.SCAN_DIV(4), .BLINK_DIV(16)) u_dut (
    .clk(clk),
    .rst(rst),
    .number_to_show(number_to_show),
    .point_position(point_position),
    .shank_position(shank_position),
    .seg(seg),
    .dig_sel(dig_sel)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic scan(input int nscans);
    int n;
    exp_t e;
    logic [5:0] m;
    logic [7:0] s;
    n = 0;
    while (dig_sel !== 6'h3E && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("sync", {26'd0, dig_sel}, 32'h3E);
    for (int j = 0; j < nscans * 6; j++) begin
      e = sb.pop_front();
      m = ~(6'b1 << e.d);
      s = (e.sh && ((k - 1) / 16) % 2 == 1) ? 8'hFF : e.code;
      check($sformatf("dig%0d_sel", e.d), {26'd0, dig_sel}, {26'd0, m});
      check($sformatf("dig%0d_seg", e.d), {24'd0, seg}, {24'd0, s});
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic show(input logic [19:0] v, input logic [5:0] pp, input logic [5:0] sh, input int nscans);
    int x;
    int dv[6];
    logic [7:0] codes[6];
    exp_t e;
`ifdef DIGITRON_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    @(negedge clk);
    number_to_show = v;
    point_position = pp;
    shank_position = sh;
    x = v > 999999 ? 999999 : int'(v);
    for (int i = 5; i >= 0; i--) begin
      dv[i] = x % 10;
      x = x / 10;
    end
    for (int i = 0; i < 6; i++) begin
      codes[i] = {~pp[i], lut[dv[i]][6:0]};
`ifdef DIGITRON_LZB_EN
      lead = lead && dv[i] == 0 && !pp[i] && i < 5;
      if (lead) codes[i] = 8'hFF;
`endif
    end
    for (int s = 0; s < nscans; s++)
      for (int i = 0; i < 6; i++) begin
        e.d = i;
        e.code = codes[i];
        e.sh = sh[i];
        sb.push_back(e);
      end
    repeat (50) @(negedge clk);
    scan(nscans);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_dig", {26'd0, dig_sel}, 32'h3F);
    rst = 1'b0;
    @(negedge clk);
    check("first_dig", {26'd0, dig_sel}, 32'h3E);
    show(20'd123456, 6'b0, 6'b0, 1);
    show(20'd1000000, 6'b0, 6'b0, 1);
    show(20'd888888, 6'b0, 6'b000100, 4);
    show(20'd888888, 6'b001000, 6'b0, 1);
    show(20'd42, 6'b0, 6'b0, 1);
    show(20'd1, 6'b0, 6'b0, 1);
    n = 0;
    while ((k - 1) % 22 != 5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("shift_phase", (k - 1) % 22, 5);
    number_to_show = 20'd2;
    repeat (16) @(negedge clk);
    check("hold_old", {8'd0, u_dut.disp}, 32'h1);
    n = 16;
    while (u_dut.disp !== 24'h2 && n < 43) begin
      @(negedge clk);
      n++;
    end
    check("update_43", {8'd0, u_dut.disp}, 32'h2);
    show(20'd2, 6'b0, 6'b0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_seg", {24'd0, seg}, 32'hFF);
    check("async_dig", {26'd0, dig_sel}, 32'h3F);
    check("async_disp", {8'd0, u_dut.disp}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/digitron_display.md
# digitron_display

Downstream display stage for the countdown timer. Takes the 20-bit binary value, per-digit decimal-point mask and per-digit blink mask produced by the timer control stage. Converts the value to six BCD digits with a sequential double-dabble engine. Time-multiplexes the digits onto a common-anode six-digit seven-segment module, with blinking on selected digits.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected (≥2).
- `BLINK_DIV`, default 12500000: clock cycles per blink half-period (≥2).
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `number_to_show`  input  20  binary value to display, nominal range 0..999999.
- `point_position`  input  6  bit i lights decimal point of digit i.
- `shank_position`  input  6  bit i makes digit i blink.
- `seg`  output  8  active-low segments, `seg[7]`=dp, `seg[6:0]`=g..a.
- `dig_sel`  output  6  active-low one-hot digit enable; bit i = digit i.
- Digit 0 is the most significant (100000s); digit 5 is units.
- One clock; reset is asynchronous and active-high.

## Operation
- Conversion FSM states:
  - IDLE: sample `number_to_show`, clamp values >999999 to 999999, load the shift register, go to SHIFT.
  - SHIFT: 20 iterations of add-3-if-≥5 then shift left; go to DONE after the 20th.
  - DONE: write the six BCD nibbles to the display register, go to IDLE.
- Conversion runs continuously, one full sample-to-update cycle every 22 clocks.
- Input changes during SHIFT are ignored until the next IDLE sample.
- Scan counter counts 0..SCAN_DIV-1. At terminal count it resets and the digit index advances 0→1→…→5→0.
- Blink counter counts 0..BLINK_DIV-1. At terminal count it toggles `blink_phase`.
- Per selected digit i:
  - segments come from the BCD→7-seg lookup of display nibble i;
  - `seg[7]` = ~`point_position[i]`;
  - if `shank_position[i]` and `blink_phase`=1, `seg` = 8'hFF (digit blanked, dp included).
- Segment codes (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Nibbles >9 cannot occur.
- Reset values:
  - `seg`=8'hFF, `dig_sel`=6'h3F;
  - display register all zero;
  - FSM IDLE;
  - scan counter, blink counter, digit index and `blink_phase` all 0.
- Reset asserted mid-conversion aborts the conversion. The display register keeps its reset value until the first DONE after release.

## Timing
- `seg`/`dig_sel` are registered. The first edge after reset release drives digit 0.
- Value latency: a sample taken in IDLE at edge n updates the display register at edge n+21. It is visible on the pins the next time that digit is scanned.
- Worst case from input change to register update: 43 cycles.
- `point_position`/`shank_position` are applied with one cycle of latency, no conversion delay.
- `dig_sel` changes on the same edge as the matching `seg` value; no blanking gap between digits.
- With both `shank_position[i]` and `point_position[i]` set during the blank phase, blank wins.

## Configuration
- `DIGITRON_LZB_EN` defined: leading-zero blanking.
  - Digits 0..4 that are zero and precede the first nonzero digit output 8'hFF.
  - Blanking stops at the first digit whose `point_position` bit is set.
  - Digit 5 is never blanked by this rule.
- `DIGITRON_LZB_EN` undefined: all six digits are always shown, leading zeros as C0.

## Structure
- Package `digitron_pkg`:
  - `NUM_DIGITS`=6;
  - `MAX_VALUE`=20'd999999;
  - conversion state enum (IDLE/SHIFT/DONE);
  - 10-entry active-low segment lookup constants.
- Sub-module `bin2bcd_seq`: the double-dabble FSM, with `start`/`busy`/`done` and a 24-bit BCD output. Top level holds scan, blink, masking and output registers.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=16.
- Hold `rst`=1 → `seg`=FF, `dig_sel`=3F. Release → `dig_sel`=3E on the next edge.
- `number_to_show`=123456, masks 0 → after 22 cycles the scan shows:
  - `dig_sel`=3E with `seg`=F9;
  - 3D with A4, 3B with B0, 37 with 99, 2F with 92, 1F with 82.
- `number_to_show`=1000000 → all digits show 90 (clamped to 999999).
- Value 888888, `shank_position`=6'b000100 → digit 2 alternates 80 / FF every 16 cycles; other digits are steady 80.
- Value 888888, `point_position`=6'b001000 → digit 3 shows 00 (dp on); the rest show 80.
- Value 42:
  - with `DIGITRON_LZB_EN`: digits 0-3 FF, digit 4 99, digit 5 A4;
  - without it: digits 0-3 show C0.
- Change the value from 1 to 2 mid-SHIFT → display shows 1 first, then 2 within 43 cycles.
